// File: rtl/uart_reg_decoder.sv
// uart_reg_decoder: oversampled 8N1 UART receiver that decodes {addr,nibble}
// bytes into a byte-wide register file. Low/high nibble pairs commit a
// register; unpaired high nibbles and bad stop bits raise one-cycle pulses.
module uart_reg_decoder #(
  parameter int CLKS_PER_BIT = 16,
  parameter int NUM_REGS     = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx,
  output logic [NUM_REGS*8-1:0] regs,
  output logic                  wr_strobe,
  output logic [2:0]            wr_index,
  output logic                  frame_err,
  output logic                  pair_err,
  output logic                  busy
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_e;

  localparam logic [9:0] FULL_RELOAD = 10'(CLKS_PER_BIT - 1);
  localparam logic [9:0] HALF_RELOAD = 10'(CLKS_PER_BIT / 2 - 1);

  state_e                   state_q, state_d;
  logic                     rx_meta_q, rx_meta_d;
  logic                     rx_s_q, rx_s_d;
  logic [1:0]               sync_fill_q, sync_fill_d;
  logic [9:0]               cnt_q, cnt_d;
  logic [2:0]               bit_q, bit_d;
  logic [7:0]               shreg_q, shreg_d;
  logic                     armed_q, armed_d;
  logic                     pend_valid_q, pend_valid_d;
  logic [2:0]               pend_index_q, pend_index_d;
  logic [3:0]               hold_q, hold_d;
  logic [NUM_REGS-1:0][7:0] regs_q, regs_d;
  logic                     wr_strobe_q, wr_strobe_d;
  logic [2:0]               wr_index_q, wr_index_d;
  logic                     frame_err_q, frame_err_d;
  logic                     pair_err_q, pair_err_d;

  logic       cnt_zero;
  logic       start_det;
  logic [2:0] dec_idx;
  logic       dec_half;
  logic [3:0] dec_data;
  logic       dec_in_range;

  assign cnt_zero     = (cnt_q == 10'd0);
  assign start_det    = (state_q == S_IDLE) && armed_q && !rx_s_q;
  assign dec_idx      = shreg_q[7:5];
  assign dec_half     = shreg_q[4];
  assign dec_data     = shreg_q[3:0];
  assign dec_in_range = (int'({1'b0, dec_idx}) < NUM_REGS);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic for the frame FSM
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_det) state_d = S_START;
      S_START: if (cnt_zero) state_d = rx_s_q ? S_IDLE : S_DATA;
      S_DATA:  if (cnt_zero && bit_q == 3'd7) state_d = S_STOP;
      S_STOP:  if (cnt_zero) state_d = rx_s_q ? S_IDLE : S_BREAK;
      S_BREAK: if (rx_s_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: synchroniser, bit timing, shifting and byte decode
  always_comb begin
    rx_meta_d    = rx;
    rx_s_d       = rx_meta_q;
    // sync_fill marks when rx_s holds a real line sample rather than its
    // reset value, so a line held low across reset cannot arm the receiver
    sync_fill_d  = {sync_fill_q[0], 1'b1};
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    shreg_d      = shreg_q;
    armed_d      = armed_q;
    pend_valid_d = pend_valid_q;
    pend_index_d = pend_index_q;
    hold_d       = hold_q;
    regs_d       = regs_q;
    wr_index_d   = wr_index_q;
    wr_strobe_d  = 1'b0;
    frame_err_d  = 1'b0;
    pair_err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sync_fill_q[1] && rx_s_q) armed_d = 1'b1;
        if (start_det) cnt_d = HALF_RELOAD;
      end
      S_START: begin
        if (!cnt_zero) cnt_d = cnt_q - 10'd1;
        else if (!rx_s_q) begin
          cnt_d = FULL_RELOAD;
          bit_d = 3'd0;
        end
      end
      S_DATA: begin
        if (!cnt_zero) cnt_d = cnt_q - 10'd1;
        else begin
          shreg_d = {rx_s_q, shreg_q[7:1]};
          cnt_d   = FULL_RELOAD;
          bit_d   = bit_q + 3'd1;
        end
      end
      S_STOP: begin
        if (!cnt_zero) cnt_d = cnt_q - 10'd1;
        else if (!rx_s_q) begin
          frame_err_d  = 1'b1;
          pend_valid_d = 1'b0;
        end else if (dec_in_range) begin
          // out-of-range indices belong to another decoder on the same line
          if (!dec_half) begin
            hold_d       = dec_data;
            pend_index_d = dec_idx;
            pend_valid_d = 1'b1;
          end else begin
            pend_valid_d = 1'b0;
            if (pend_valid_q && pend_index_q == dec_idx) begin
              for (int i = 0; i < NUM_REGS; i++)
                if (dec_idx == 3'(i)) regs_d[i] = {dec_data, hold_q};
              wr_strobe_d = 1'b1;
              wr_index_d  = dec_idx;
            end else begin
              pair_err_d = 1'b1;
            end
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      sync_fill_q  <= 2'b00;
      cnt_q        <= 10'd0;
      bit_q        <= 3'd0;
      shreg_q      <= 8'd0;
      armed_q      <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_index_q <= 3'd0;
      hold_q       <= 4'd0;
      regs_q       <= '0;
      wr_strobe_q  <= 1'b0;
      wr_index_q   <= 3'd0;
      frame_err_q  <= 1'b0;
      pair_err_q   <= 1'b0;
    end else begin
      rx_meta_q    <= rx_meta_d;
      rx_s_q       <= rx_s_d;
      sync_fill_q  <= sync_fill_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      shreg_q      <= shreg_d;
      armed_q      <= armed_d;
      pend_valid_q <= pend_valid_d;
      pend_index_q <= pend_index_d;
      hold_q       <= hold_d;
      regs_q       <= regs_d;
      wr_strobe_q  <= wr_strobe_d;
      wr_index_q   <= wr_index_d;
      frame_err_q  <= frame_err_d;
      pair_err_q   <= pair_err_d;
    end
  end

  // Outputs
  always_comb begin
    regs      = regs_q;
    wr_strobe = wr_strobe_q;
    wr_index  = wr_index_q;
    frame_err = frame_err_q;
    pair_err  = pair_err_q;
    busy      = (state_q != S_IDLE);
  end

endmodule

// File: tb/tb_uart_reg_decoder.sv
// Bench: two decoders (8 and 2 registers) share one serial line. Each frame
// sent pushes its expected pulse events into per-decoder queues; monitors pop
// and compare whenever a decoder raises a pulse.
module tb_uart_reg_decoder;
  localparam int CPB = 16;
  localparam int NR0 = 8;
  localparam int NR1 = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx = 1'b1;
  logic [NR0*8-1:0] regs0;
  logic [NR1*8-1:0] regs1;
  logic ws0, ws1, fe0, fe1, pe0, pe1, busy0, busy1;
  logic [2:0] wi0, wi1;

  uart_reg_decoder #(.CLKS_PER_BIT(CPB), .NUM_REGS(NR0)) dut0 (
    .clk(clk), .rst_n(rst_n), .rx(rx), .regs(regs0), .wr_strobe(ws0),
    .wr_index(wi0), .frame_err(fe0), .pair_err(pe0), .busy(busy0));
  uart_reg_decoder #(.CLKS_PER_BIT(CPB), .NUM_REGS(NR1)) dut1 (
    .clk(clk), .rst_n(rst_n), .rx(rx), .regs(regs1), .wr_strobe(ws1),
    .wr_index(wi1), .frame_err(fe1), .pair_err(pe1), .busy(busy1));

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0]  kind;   // {wr_strobe, pair_err, frame_err}
    logic [2:0]  idx;
    logic [63:0] regs;
    longint      cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int n_vec = 0;
  int n_err = 0;

  // reference model: per-decoder register file and pairing state
  logic [7:0] m_regs [2][8];
  logic       m_pv   [2];
  logic [2:0] m_pi   [2];
  logic [3:0] m_hold [2];
  logic [2:0] m_last [2];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic int nregs(input int d);
    return (d == 0) ? NR0 : NR1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 8; i++) m_regs[d][i] = 8'h00;
      m_pv[d] = 1'b0; m_pi[d] = 3'd0; m_hold[d] = 4'd0; m_last[d] = 3'd0;
    end
    q0.delete();
    q1.delete();
  endtask

  task automatic push(input int d, input logic [2:0] kind, input longint ts);
    exp_t e;
    e.kind = kind;
    e.idx  = m_last[d];
    e.regs = '0;
    for (int i = 0; i < nregs(d); i++) e.regs[8*i +: 8] = m_regs[d][i];
    e.cyc  = ts;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic model_byte(input logic [7:0] b, input bit good, input longint ts);
    logic [2:0] ix;
    logic       hf;
    logic [3:0] dt;
    ix = b[7:5]; hf = b[4]; dt = b[3:0];
    for (int d = 0; d < 2; d++) begin
      if (!good) begin
        m_pv[d] = 1'b0;
        push(d, 3'b001, ts);
      end else if (int'(ix) < nregs(d)) begin
        if (!hf) begin
          m_hold[d] = dt; m_pi[d] = ix; m_pv[d] = 1'b1;
        end else begin
          if (m_pv[d] && m_pi[d] == ix) begin
            m_regs[d][ix] = {dt, m_hold[d]};
            m_last[d] = ix;
            push(d, 3'b100, ts);
          end else begin
            push(d, 3'b010, ts);
          end
          m_pv[d] = 1'b0;
        end
      end
    end
  endtask

  task automatic check_evt(input int d, input logic [2:0] kind, input logic [2:0] wi,
                           input logic [63:0] r);
    exp_t e;
    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
      n_vec++; n_err++;
      $display("FAIL unexpected_event dut%0d: pulses %b at cycle %0d, none expected", d, kind, cyc);
      return;
    end
    if (d == 0) e = q0.pop_front();
    else        e = q1.pop_front();
    chk($sformatf("evt_kind dut%0d", d), {61'd0, kind}, {61'd0, e.kind});
    chk($sformatf("evt_cycle dut%0d", d), cyc, e.cyc);
    chk($sformatf("wr_index dut%0d", d), {61'd0, wi}, {61'd0, e.idx});
    chk($sformatf("regs dut%0d", d), r, e.regs);
  endtask

  // monitors: one per decoder, sampling on the falling edge
  always @(negedge clk)
    if (rst_n && (ws0 | pe0 | fe0)) check_evt(0, {ws0, pe0, fe0}, wi0, {{(64-NR0*8){1'b0}}, regs0});
  always @(negedge clk)
    if (rst_n && (ws1 | pe1 | fe1)) check_evt(1, {ws1, pe1, fe1}, wi1, {{(64-NR1*8){1'b0}}, regs1});

  // stop_low = 0: good frame; otherwise stop bit held low that many bit times
  task automatic send_frame(input logic [7:0] b, input int stop_low);
    longint c0;
    @(negedge clk);
    c0 = cyc;
    model_byte(b, stop_low == 0, c0 + 3 + CPB/2 + 9*CPB);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      rx = b[k];
      repeat (CPB) @(negedge clk);
    end
    if (stop_low == 0) begin
      rx = 1'b1;
      repeat (CPB - 1) @(negedge clk);
    end else begin
      rx = 1'b0;
      repeat (stop_low*CPB) @(negedge clk);
      chk("break_busy_held", {63'd0, busy0 & busy1}, 64'd1);
      rx = 1'b1;
      repeat (CPB) @(negedge clk);
      chk("break_exit_busy", {62'd0, busy0, busy1}, 64'd0);
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_regs0"}, regs0, 64'd0);
    chk({tag, "_regs1"}, {48'd0, regs1}, 64'd0);
    chk({tag, "_ctl0"}, {57'd0, ws0, wi0, fe0, pe0, busy0}, 64'd0);
    chk({tag, "_ctl1"}, {57'd0, ws1, wi1, fe1, pe1, busy1}, 64'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: run exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    longint c0;
    int bad;
    model_reset();
    repeat (3) @(negedge clk);
    chk_zero_outputs("reset");
    rst_n = 1'b1;
    idle(10);

    // basic pair, then mismatched pairing
    send_frame(8'h45, 0);
    send_frame(8'h5A, 0);
    idle(4);
    send_frame(8'h45, 0);
    send_frame(8'h7A, 0);
    send_frame(8'h7B, 0);
    idle(4);

    // frame error with long break, then recovery
    send_frame(8'h01, 3);
    send_frame(8'h0C, 0);
    send_frame(8'h03, 0);
    idle(4);

    // indices beyond the small decoder
    send_frame(8'h41, 0);
    send_frame(8'h52, 0);
    send_frame(8'h2F, 0);
    send_frame(8'h31, 0);
    idle(8);

    // short low glitch while idle
    @(negedge clk);
    c0 = cyc;
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    chk("glitch_busy_at_T0", {63'd0, busy0}, 64'd1);
    repeat (7) @(negedge clk);
    chk("glitch_busy_before_T0p8", {63'd0, busy0}, 64'd1);
    @(negedge clk);
    chk("glitch_idle_after_T0p8", {62'd0, busy0, busy1}, 64'd0);
    chk("glitch_cycle", cyc - c0, 64'd11);
    idle(10);

    // reset in the middle of a data bit with the line held low
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (3*CPB) @(negedge clk);
    rx = 1'b0;
    repeat (CPB/2) @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (4*CPB) begin
      @(negedge clk);
      if (busy0 | busy1) bad++;
    end
    chk("no_false_start_after_reset", bad, 64'd0);
    chk_zero_outputs("post_reset");
    idle(6);
    send_frame(8'h45, 0);
    send_frame(8'h5A, 0);
    send_frame(8'h2F, 0);
    send_frame(8'h31, 0);
    idle(4);

    // randomized traffic
    for (int n = 0; n < 70; n++) begin
      int mode;
      logic [2:0] ix;
      mode = $urandom_range(0, 9);
      ix = 3'($urandom_range(0, 7));
      if (mode <= 5) begin
        send_frame({ix, 1'b0, 4'($urandom_range(0, 15))}, 0);
        if ($urandom_range(0, 1) == 0) idle($urandom_range(0, 3));
        send_frame({ix, 1'b1, 4'($urandom_range(0, 15))}, 0);
      end else if (mode <= 7) begin
        send_frame(8'($urandom_range(0, 255)), 0);
      end else if (mode == 8) begin
        send_frame(8'($urandom_range(0, 255)), $urandom_range(1, 2));
      end else begin
        send_frame({ix, 1'b1, 4'($urandom_range(0, 15))}, 0);
      end
      idle($urandom_range(0, 3));
    end

    idle(3*CPB);
    chk("leftover_expected_dut0", q0.size(), 64'd0);
    chk("leftover_expected_dut1", q1.size(), 64'd0);
    begin
      logic [63:0] r0, r1;
      r0 = '0; r1 = '0;
      for (int i = 0; i < NR0; i++) r0[8*i +: 8] = m_regs[0][i];
      for (int i = 0; i < NR1; i++) r1[8*i +: 8] = m_regs[1][i];
      chk("final_regs0", regs0, r0);
      chk("final_regs1", {48'd0, regs1}, r1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
